image_crop: RTL and testbench

Parametrised, frame-synchronous crop stage for the DVP video path, placed between the capture/scaler output and the framebuffer writer. It counts input pixel positions from the DE/VS strobes alone, so no fixed H_DISP/V_DISP is needed. Only pixels inside a rectangular window are passed on, with crop-relative coordinates. The window configuration is shadowed and only takes effect at frame boundaries. All outputs are registered.

---
 rtl/image_pkg.sv | 34 +++
 rtl/image_crop_pix_counter.sv | 106 ++++++++++
 rtl/image_crop.sv | 155 +++++++++++++++
 tb/tb_image_crop.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/image_pkg.sv
// Shared types and defaults for the DVP crop/OSD/scaler stages.
// window_t carries a crop rectangle plus its enable; coordinates are held at
// COORD_W bits so stages with different X_W/Y_W (up to COORD_W) can share it.
package image_pkg;

    localparam int IMG_DATA_W = 24;
    localparam int IMG_X_W    = 12;
    localparam int IMG_Y_W    = 12;

    // Storage width of window coordinates; X_W/Y_W must not exceed this.
    localparam int COORD_W    = 16;

    // Rectangle is [sx, ex) x [sy, ey); en = 0 means full-frame pass-through.
    typedef struct packed {
        logic [COORD_W-1:0] sx;
        logic [COORD_W-1:0] sy;
        logic [COORD_W-1:0] ex;
        logic [COORD_W-1:0] ey;
        logic               en;
    } window_t;

    // A window is empty when either span has no columns/rows in it.
    function automatic logic window_empty(input window_t w);
        return (w.ex <= w.sx) || (w.ey <= w.sy);
    endfunction

    // Unsigned inclusive-start / exclusive-end containment test.
    function automatic logic in_window(input window_t w,
                                       input logic [COORD_W-1:0] x,
                                       input logic [COORD_W-1:0] y);
        return (x >= w.sx) && (x < w.ex) && (y >= w.sy) && (y < w.ey);
    endfunction

endpackage

// File: rtl/image_crop_pix_counter.sv
// pix_counter: derives pixel column/row from the VS/DE strobes alone.
// Detects VS rising and DE falling edges, keeps saturating column/row counters
// and presents the counter value that applies to the pixel on the inputs this
// cycle (pre-increment; forced to 0 while VS is high).
// Optional macro IMAGE_CROP_MEASURE_EN adds o_meas_w/o_meas_h: the previous
// frame's longest line (DE-high count) and line count, loaded at VS rise.
// A line is closed by its DE falling edge, so frames should end with DE low
// before the next VS rise.
module pix_counter #(
    parameter int X_W = 12,
    parameter int Y_W = 12
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_vs,
    input  logic           i_de,
    output logic [X_W-1:0] o_pix_x,
    output logic [Y_W-1:0] o_pix_y,
    output logic           o_vs_rise
`ifdef IMAGE_CROP_MEASURE_EN
    ,
    output logic [X_W-1:0] o_meas_w,
    output logic [Y_W-1:0] o_meas_h
`endif
);

    localparam logic [X_W-1:0] X_MAX = '1;
    localparam logic [Y_W-1:0] Y_MAX = '1;
    localparam logic [X_W-1:0] X_ONE = X_W'(1);
    localparam logic [Y_W-1:0] Y_ONE = Y_W'(1);

    logic           r_vs_d;
    logic           r_de_d;
    logic [X_W-1:0] r_pix_x;
    logic [Y_W-1:0] r_pix_y;
    logic           w_vs_rise;
    logic           w_de_fall;

    assign w_vs_rise = i_vs & ~r_vs_d;
    assign w_de_fall = r_de_d & ~i_de;

    // A pixel arriving with VS high is treated as (0,0) of the new frame.
    assign o_pix_x   = i_vs ? '0 : r_pix_x;
    assign o_pix_y   = i_vs ? '0 : r_pix_y;
    assign o_vs_rise = w_vs_rise;

    // Delayed strobes for edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vs_d <= 1'b0;
            r_de_d <= 1'b0;
        end else begin
            r_vs_d <= i_vs;
            r_de_d <= i_de;
        end
    end

    // Saturating column/row counters; frame start has priority over counting.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pix_x <= '0;
            r_pix_y <= '0;
        end else if (w_vs_rise) begin
            // A pixel coincident with VS rise occupies column 0.
            r_pix_x <= i_de ? X_ONE : '0;
            r_pix_y <= '0;
        end else if (i_vs) begin
            r_pix_x <= '0;
            r_pix_y <= '0;
        end else if (i_de) begin
            if (r_pix_x != X_MAX) begin
                r_pix_x <= r_pix_x + X_ONE;
            end
        end else if (w_de_fall) begin
            r_pix_x <= '0;
            if (r_pix_y != Y_MAX) begin
                r_pix_y <= r_pix_y + Y_ONE;
            end
        end
    end

`ifdef IMAGE_CROP_MEASURE_EN
    logic [X_W-1:0] r_max_w;
    logic [X_W-1:0] r_meas_w;
    logic [Y_W-1:0] r_meas_h;

    // Track the longest line of the running frame, publish it at VS rise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_max_w  <= '0;
            r_meas_w <= '0;
            r_meas_h <= '0;
        end else if (w_vs_rise) begin
            r_meas_w <= r_max_w;
            r_meas_h <= r_pix_y;
            r_max_w  <= '0;
        end else if (!i_vs && w_de_fall && (r_pix_x > r_max_w)) begin
            r_max_w <= r_pix_x;
        end
    end

    assign o_meas_w = r_meas_w;
    assign o_meas_h = r_meas_h;
`endif

endmodule

// File: rtl/image_crop.sv
// image_crop: frame-synchronous rectangular crop for the DVP video path.
// Pixels inside the shadowed window are forwarded with crop-relative x/y;
// everything else is blanked (de_o = 0, data_o = 0). The window is loaded
// from cfg_* only at VS rising edges. All outputs are registered, 1 cycle
// latency, no backpressure.
// Optional macro IMAGE_CROP_MEASURE_EN adds meas_w/meas_h (previous frame's
// longest line and line count). cfg_err flags an enabled but empty window.
module image_crop
    import image_pkg::*;
#(
    parameter int DATA_W = IMG_DATA_W,
    parameter int X_W    = IMG_X_W,
    parameter int Y_W    = IMG_Y_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_en,
    input  logic [X_W-1:0]    cfg_start_x,
    input  logic [Y_W-1:0]    cfg_start_y,
    input  logic [X_W-1:0]    cfg_end_x,
    input  logic [Y_W-1:0]    cfg_end_y,
    input  logic              vs_i,
    input  logic              de_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              vs_o,
    output logic              de_o,
    output logic [DATA_W-1:0] data_o,
    output logic [X_W-1:0]    x_o,
    output logic [Y_W-1:0]    y_o,
    output logic              frame_done,
    output logic              cfg_err
`ifdef IMAGE_CROP_MEASURE_EN
    ,
    output logic [X_W-1:0]    meas_w,
    output logic [Y_W-1:0]    meas_h
`endif
);

    logic           w_vs_rise;
    logic [X_W-1:0] w_pix_x;
    logic [Y_W-1:0] w_pix_y;

    window_t        w_cfg_win;
    window_t        w_act_win;
    window_t        r_shadow;

    logic           r_armed;
    logic           w_armed;
    logic           w_in_range;
    logic           w_in_win;
    logic [X_W-1:0] w_off_x;
    logic [Y_W-1:0] w_off_y;
    logic [X_W-1:0] w_rel_x;
    logic [Y_W-1:0] w_rel_y;

    logic              r_vs_o;
    logic              r_de_o;
    logic [DATA_W-1:0] r_data_o;
    logic [X_W-1:0]    r_x_o;
    logic [Y_W-1:0]    r_y_o;
    logic              r_frame_done;
    logic              r_cfg_err;
    logic              r_emitted;

    pix_counter #(
        .X_W (X_W),
        .Y_W (Y_W)
    ) u_pix_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_vs      (vs_i),
        .i_de      (de_i),
        .o_pix_x   (w_pix_x),
        .o_pix_y   (w_pix_y),
        .o_vs_rise (w_vs_rise)
`ifdef IMAGE_CROP_MEASURE_EN
        ,
        .o_meas_w  (meas_w),
        .o_meas_h  (meas_h)
`endif
    );

    // Window selection and compare; at VS rise the incoming cfg is already in
    // force so a pixel on that edge is tested against the new window.
    always_comb begin
        w_cfg_win    = '0;
        w_cfg_win.sx = COORD_W'(cfg_start_x);
        w_cfg_win.sy = COORD_W'(cfg_start_y);
        w_cfg_win.ex = COORD_W'(cfg_end_x);
        w_cfg_win.ey = COORD_W'(cfg_end_y);
        w_cfg_win.en = cfg_en;

        w_act_win  = w_vs_rise ? w_cfg_win : r_shadow;
        // Output stays suppressed from reset until a window has been loaded.
        w_armed    = r_armed | w_vs_rise;
        w_in_range = in_window(w_act_win, COORD_W'(w_pix_x), COORD_W'(w_pix_y));
        w_in_win   = w_armed & de_i & (w_act_win.en ? w_in_range : 1'b1);

        // In pass-through the coordinates are the raw frame position.
        w_off_x = w_act_win.en ? X_W'(w_act_win.sx) : '0;
        w_off_y = w_act_win.en ? Y_W'(w_act_win.sy) : '0;
        w_rel_x = w_pix_x - w_off_x;
        w_rel_y = w_pix_y - w_off_y;
    end

    // Registered video outputs; blanked fields are forced to zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vs_o   <= 1'b0;
            r_de_o   <= 1'b0;
            r_data_o <= '0;
            r_x_o    <= '0;
            r_y_o    <= '0;
        end else begin
            r_vs_o   <= vs_i;
            r_de_o   <= w_in_win;
            r_data_o <= w_in_win ? data_i  : '0;
            r_x_o    <= w_in_win ? w_rel_x : '0;
            r_y_o    <= w_in_win ? w_rel_y : '0;
        end
    end

    // Shadow window, arm flag and frame status; all updated at VS rise only,
    // except the sticky emitted flag which also follows output pixels.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shadow     <= '0;
            r_armed      <= 1'b0;
            r_cfg_err    <= 1'b0;
            r_frame_done <= 1'b0;
            r_emitted    <= 1'b0;
        end else begin
            r_frame_done <= w_vs_rise & r_emitted;
            if (w_vs_rise) begin
                r_shadow  <= w_cfg_win;
                r_armed   <= 1'b1;
                // Pass-through never has an empty window.
                r_cfg_err <= w_cfg_win.en & window_empty(w_cfg_win);
                // A pixel on the VS edge belongs to the new frame.
                r_emitted <= w_in_win;
            end else if (w_in_win) begin
                r_emitted <= 1'b1;
            end
        end
    end

    assign vs_o       = r_vs_o;
    assign de_o       = r_de_o;
    assign data_o     = r_data_o;
    assign x_o        = r_x_o;
    assign y_o        = r_y_o;
    assign frame_done = r_frame_done;
    assign cfg_err    = r_cfg_err;

endmodule

// File: tb/tb_image_crop.sv
// Bench for image_crop. Each driven input cycle pushes the expected output
// bundle {vs_o, de_o, frame_done, cfg_err, x_o, y_o, data_o} to exp_q; the
// scoreboard pops one entry per clock and compares. Expected values come from
// the frame geometry (row/column known to the driver), not from strobes.
// Build with +define+IMAGE_CROP_MEASURE_EN to include the measurement test.
module tb_image_crop;

  localparam int DATA_W = 24;
  localparam int X_W    = 12;
  localparam int Y_W    = 12;
  localparam int BW     = 4 + X_W + Y_W + DATA_W;

  // clock / reset block
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic              cfg_en;
  logic [X_W-1:0]    cfg_start_x;
  logic [Y_W-1:0]    cfg_start_y;
  logic [X_W-1:0]    cfg_end_x;
  logic [Y_W-1:0]    cfg_end_y;
  logic              vs_i;
  logic              de_i;
  logic [DATA_W-1:0] data_i;
  logic              vs_o;
  logic              de_o;
  logic [DATA_W-1:0] data_o;
  logic [X_W-1:0]    x_o;
  logic [Y_W-1:0]    y_o;
  logic              frame_done;
  logic              cfg_err;
`ifdef IMAGE_CROP_MEASURE_EN
  logic [X_W-1:0]    meas_w;
  logic [Y_W-1:0]    meas_h;
`endif

  image_crop #(
    .DATA_W (DATA_W),
    .X_W    (X_W),
    .Y_W    (Y_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_en      (cfg_en),
    .cfg_start_x (cfg_start_x),
    .cfg_start_y (cfg_start_y),
    .cfg_end_x   (cfg_end_x),
    .cfg_end_y   (cfg_end_y),
    .vs_i        (vs_i),
    .de_i        (de_i),
    .data_i      (data_i),
    .vs_o        (vs_o),
    .de_o        (de_o),
    .data_o      (data_o),
    .x_o         (x_o),
    .y_o         (y_o),
    .frame_done  (frame_done),
    .cfg_err     (cfg_err)
`ifdef IMAGE_CROP_MEASURE_EN
    ,
    .meas_w      (meas_w),
    .meas_h      (meas_h)
`endif
  );

  // scoreboard state
  logic [BW-1:0] exp_q[$];
  int n_tests   = 0;
  int n_fail    = 0;
  int n_de_seen = 0;
  int n_fd_seen = 0;

  // reference state: window latched at each VS rise, arm/emitted/err flags
  logic m_last_vs = 1'b0;
  logic m_armed   = 1'b0;
  logic m_emitted = 1'b0;
  logic m_err     = 1'b0;
  logic m_en      = 1'b0;
  int   m_sx = 0, m_sy = 0, m_ex = 0, m_ey = 0;

  // scoreboard: one expected entry per clock, compared #1 after the edge
  always @(posedge clk) begin
    logic [BW-1:0] got;
    logic [BW-1:0] exp;
    #1;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      got = {vs_o, de_o, frame_done, cfg_err, x_o, y_o, data_o};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL sb_out t=%0t got=%h exp=%h", $time, got, exp);
      end
    end
    if (de_o === 1'b1) n_de_seen++;
    if (frame_done === 1'b1) n_fd_seen++;
  end

  // watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic set_cfg(input logic en, input int sx, input int sy, input int ex, input int ey);
    cfg_en      = en;
    cfg_start_x = X_W'(sx);
    cfg_start_y = Y_W'(sy);
    cfg_end_x   = X_W'(ex);
    cfg_end_y   = Y_W'(ey);
  endtask

  task automatic drive(input logic vs, input logic de, input int r, input int c);
    logic [DATA_W-1:0] d;
    logic              rise;
    logic              fd;
    logic              in_w;
    logic [X_W-1:0]    ex_x;
    logic [Y_W-1:0]    ex_y;
    logic [DATA_W-1:0] ex_d;
    @(negedge clk);
    d      = DATA_W'($urandom());
    rst_n  = 1'b1;
    vs_i   = vs;
    de_i   = de;
    data_i = d;
    rise = vs && !m_last_vs;
    m_last_vs = vs;
    fd = 1'b0;
    if (rise) begin
      fd      = m_emitted;
      m_en    = cfg_en;
      m_sx    = int'(cfg_start_x);
      m_sy    = int'(cfg_start_y);
      m_ex    = int'(cfg_end_x);
      m_ey    = int'(cfg_end_y);
      m_armed = 1'b1;
      m_err   = m_en && ((m_ex <= m_sx) || (m_ey <= m_sy));
    end
    in_w = m_armed && de && (!m_en || ((c >= m_sx) && (c < m_ex) && (r >= m_sy) && (r < m_ey)));
    m_emitted = rise ? in_w : (m_emitted | in_w);
    ex_x = in_w ? X_W'(m_en ? c - m_sx : c) : X_W'(0);
    ex_y = in_w ? Y_W'(m_en ? r - m_sy : r) : Y_W'(0);
    ex_d = in_w ? d : DATA_W'(0);
    exp_q.push_back({vs, in_w, fd, m_err, ex_x, ex_y, ex_d});
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst_n  = 1'b0;
      vs_i   = 1'b0;
      de_i   = 1'b0;
      data_i = DATA_W'($urandom());
      m_armed   = 1'b0;
      m_emitted = 1'b0;
      m_err     = 1'b0;
      m_last_vs = 1'b0;
      exp_q.push_back({BW{1'b0}});
    end
  endtask

  task automatic vs_pulse();
    drive(1'b1, 1'b0, 0, 0);
    drive(1'b1, 1'b0, 0, 0);
    drive(1'b0, 1'b0, 0, 0);
  endtask

  task automatic send_rows(input int w, input int r0, input int r1);
    for (int r = r0; r < r1; r++) begin
      for (int c = 0; c < w; c++) drive(1'b0, 1'b1, r, c);
      drive(1'b0, 1'b0, r, w);
      drive(1'b0, 1'b0, r, w);
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // scenarios
  task automatic test_reset();
    do_reset(2);
    settle();
    n_tests++;
    if ({vs_o, de_o, frame_done, cfg_err} !== 4'b0 || data_o !== '0 || x_o !== '0 || y_o !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%b%b%b%b d=%h x=%h y=%h exp=all zero",
               vs_o, de_o, frame_done, cfg_err, data_o, x_o, y_o);
    end
`ifdef IMAGE_CROP_MEASURE_EN
    n_tests++;
    if (meas_w !== '0 || meas_h !== '0) begin
      n_fail++;
      $display("FAIL reset_meas got=%0d/%0d exp=0/0", meas_w, meas_h);
    end
`endif
  endtask

  task automatic test_no_vs_after_reset();
    int de0;
    set_cfg(1'b0, 0, 0, 8, 4);
    de0 = n_de_seen;
    send_rows(8, 0, 2);
    settle();
    n_tests++;
    if (n_de_seen - de0 !== 0) begin
      n_fail++;
      $display("FAIL no_vs_de_count got=%0d exp=0", n_de_seen - de0);
    end
  endtask

  task automatic test_basic_crop();
    int de0;
    set_cfg(1'b1, 2, 1, 6, 3);
    de0 = n_de_seen;
    vs_pulse();
    send_rows(8, 0, 4);
    settle();
    n_tests++;
    if (n_de_seen - de0 !== 8) begin
      n_fail++;
      $display("FAIL basic_de_count got=%0d exp=8", n_de_seen - de0);
    end
  endtask

  task automatic test_mid_frame_reconfig();
    int de0;
    int fd0;
    fd0 = n_fd_seen;
    de0 = n_de_seen;
    vs_pulse();
    settle();
    n_tests++;
    if (n_fd_seen - fd0 !== 1) begin
      n_fail++;
      $display("FAIL basic_frame_done got=%0d exp=1", n_fd_seen - fd0);
    end
    send_rows(8, 0, 2);
    set_cfg(1'b1, 0, 0, 4, 4);
    send_rows(8, 2, 4);
    settle();
    n_tests++;
    if (n_de_seen - de0 !== 8) begin
      n_fail++;
      $display("FAIL reconf_cur_count got=%0d exp=8", n_de_seen - de0);
    end
    de0 = n_de_seen;
    vs_pulse();
    send_rows(8, 0, 4);
    settle();
    n_tests++;
    if (n_de_seen - de0 !== 16) begin
      n_fail++;
      $display("FAIL reconf_next_count got=%0d exp=16", n_de_seen - de0);
    end
  endtask

  task automatic test_empty_window();
    int de0;
    int fd0;
    set_cfg(1'b1, 3, 0, 3, 4);
    de0 = n_de_seen;
    vs_pulse();
    send_rows(8, 0, 4);
    settle();
    n_tests++;
    if (n_de_seen - de0 !== 0) begin
      n_fail++;
      $display("FAIL empty_de_count got=%0d exp=0", n_de_seen - de0);
    end
    n_tests++;
    if (cfg_err !== 1'b1) begin
      n_fail++;
      $display("FAIL empty_cfg_err got=%b exp=1", cfg_err);
    end
    set_cfg(1'b0, 1, 1, 2, 2);
    fd0 = n_fd_seen;
    vs_pulse();
    settle();
    n_tests++;
    if (n_fd_seen - fd0 !== 0) begin
      n_fail++;
      $display("FAIL empty_frame_done got=%0d exp=0", n_fd_seen - fd0);
    end
  endtask

  task automatic test_bypass();
    int de0;
    de0 = n_de_seen;
    send_rows(8, 0, 4);
    settle();
    n_tests++;
    if (n_de_seen - de0 !== 32) begin
      n_fail++;
      $display("FAIL bypass_de_count got=%0d exp=32", n_de_seen - de0);
    end
    n_tests++;
    if (cfg_err !== 1'b0) begin
      n_fail++;
      $display("FAIL bypass_cfg_err got=%b exp=0", cfg_err);
    end
  endtask

  task automatic test_vs_de_overlap();
    int de0;
    int fd0;
    set_cfg(1'b1, 0, 0, 3, 2);
    de0 = n_de_seen;
    fd0 = n_fd_seen;
    drive(1'b1, 1'b1, 0, 0);
    for (int c = 1; c < 8; c++) drive(1'b0, 1'b1, 0, c);
    drive(1'b0, 1'b0, 0, 8);
    drive(1'b0, 1'b0, 0, 8);
    send_rows(8, 1, 4);
    settle();
    n_tests++;
    if (n_de_seen - de0 !== 6) begin
      n_fail++;
      $display("FAIL overlap_de_count got=%0d exp=6", n_de_seen - de0);
    end
    n_tests++;
    if (n_fd_seen - fd0 !== 1) begin
      n_fail++;
      $display("FAIL overlap_frame_done got=%0d exp=1", n_fd_seen - fd0);
    end
  endtask

  task automatic test_reset_mid_line();
    int de0;
    int fd0;
    set_cfg(1'b1, 2, 1, 6, 3);
    vs_pulse();
    send_rows(8, 0, 1);
    de0 = n_de_seen;
    for (int c = 0; c < 3; c++) drive(1'b0, 1'b1, 1, c);
    do_reset(1);
    settle();
    n_tests++;
    if ({vs_o, de_o, frame_done, cfg_err} !== 4'b0 || data_o !== '0 || x_o !== '0 || y_o !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs got=%b%b%b%b d=%h x=%h y=%h exp=all zero",
               vs_o, de_o, frame_done, cfg_err, data_o, x_o, y_o);
    end
    for (int c = 3; c < 8; c++) drive(1'b0, 1'b1, 1, c);
    drive(1'b0, 1'b0, 1, 8);
    drive(1'b0, 1'b0, 1, 8);
    send_rows(8, 2, 4);
    settle();
    n_tests++;
    if (n_de_seen - de0 !== 1) begin
      n_fail++;
      $display("FAIL midreset_de_count got=%0d exp=1", n_de_seen - de0);
    end
    fd0 = n_fd_seen;
    de0 = n_de_seen;
    vs_pulse();
    send_rows(8, 0, 4);
    settle();
    n_tests++;
    if (n_fd_seen - fd0 !== 0) begin
      n_fail++;
      $display("FAIL midreset_frame_done got=%0d exp=0", n_fd_seen - fd0);
    end
    n_tests++;
    if (n_de_seen - de0 !== 8) begin
      n_fail++;
      $display("FAIL midreset_rearm_count got=%0d exp=8", n_de_seen - de0);
    end
  endtask

`ifdef IMAGE_CROP_MEASURE_EN
  task automatic test_measure();
    vs_pulse();
    send_rows(10, 0, 6);
    vs_pulse();
    settle();
    n_tests++;
    if (meas_w !== X_W'(10) || meas_h !== Y_W'(6)) begin
      n_fail++;
      $display("FAIL meas_10x6 got=%0d/%0d exp=10/6", meas_w, meas_h);
    end
    send_rows(7, 0, 3);
    vs_pulse();
    settle();
    n_tests++;
    if (meas_w !== X_W'(7) || meas_h !== Y_W'(3)) begin
      n_fail++;
      $display("FAIL meas_7x3 got=%0d/%0d exp=7/3", meas_w, meas_h);
    end
  endtask
`endif

  // sequence and final report
  initial begin
    rst_n  = 1'b0;
    vs_i   = 1'b0;
    de_i   = 1'b0;
    data_i = '0;
    set_cfg(1'b0, 0, 0, 0, 0);
    test_reset();
    test_no_vs_after_reset();
    test_basic_crop();
    test_mid_frame_reconfig();
    test_empty_window();
    test_bypass();
    test_vs_de_overlap();
    test_reset_mid_line();
`ifdef IMAGE_CROP_MEASURE_EN
    test_measure();
`endif
    settle();
    settle();
    n_tests++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL sb_drain got=%0d entries left exp=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
